// File: rtl/mem_port_ctrl.sv
// Single-port shared-memory access controller: accepts one core command, requests the
// arbiter, completes on grant, then holds the response. Optional grant-wait timeout: MEM_PORT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command
// REQ   | request line asserted, waiting for the matching grant
// RESP  | response valid, waiting for core to accept
module mem_port_ctrl #(
   parameter int BUS_SIZE  = 128,
   parameter int TIMEOUT   = 255,
   parameter int ADDR_SIZE = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_we,
   input  logic [ADDR_SIZE-1:0] i_cmd_addr,
   input  logic [BUS_SIZE-1:0]  i_cmd_wdata,
   input  logic [2:0]           i_cmd_size,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [BUS_SIZE-1:0]  o_rsp_rdata,
   output logic                 o_rsp_err,
   output logic                 o_req_rd,
   output logic                 o_req_wr,
   input  logic                 i_grant_rd,
   input  logic                 i_grant_wr,
   output logic [ADDR_SIZE-1:0] o_proc_addr,
   output logic [BUS_SIZE-1:0]  o_proc_wr,
   output logic [2:0]           o_wr_size,
   input  logic [BUS_SIZE-1:0]  i_proc_rd
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_port_ctrl: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   we_q, we_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [BUS_SIZE-1:0]    wdata_q, wdata_d;
   logic [2:0]             size_q, size_d;
   logic                   req_rd_q, req_rd_d;
   logic                   req_wr_q, req_wr_d;
   logic [BUS_SIZE-1:0]    rdata_q, rdata_d;
   logic                   grant_hit;

`ifdef MEM_PORT_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
`endif

   // Only the grant matching the registered direction can complete a command.
   assign grant_hit = we_q ? i_grant_wr : i_grant_rd;

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      req_rd_d = req_rd_q;
      req_wr_d = req_wr_q;
      rdata_d  = rdata_q;
`ifdef MEM_PORT_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid) begin
               state_d  = ST_REQ;
               we_d     = i_cmd_we;
               addr_d   = i_cmd_addr;
               wdata_d  = i_cmd_wdata;
               size_d   = i_cmd_size;
               req_wr_d = i_cmd_we;
               req_rd_d = !i_cmd_we;
`ifdef MEM_PORT_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         ST_REQ: begin
            if (grant_hit) begin
               state_d  = ST_RESP;
               req_rd_d = 1'b0;
               req_wr_d = 1'b0;
               rdata_d  = we_q ? '0 : i_proc_rd;
`ifdef MEM_PORT_TIMEOUT_EN
               err_d    = 1'b0;
`endif
            end
`ifdef MEM_PORT_TIMEOUT_EN
            // cnt_q counts unmatched REQ cycles already elapsed; this edge would make it TIMEOUT.
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d  = ST_RESP;
               req_rd_d = 1'b0;
               req_wr_d = 1'b0;
               rdata_d  = '0;
               err_d    = 1'b1;
            end else begin
               cnt_d    = cnt_q + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            req_rd_d = 1'b0;
            req_wr_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= '0;
         req_rd_q <= 1'b0;
         req_wr_q <= 1'b0;
         rdata_q  <= '0;
`ifdef MEM_PORT_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         req_rd_q <= req_rd_d;
         req_wr_q <= req_wr_d;
         rdata_q  <= rdata_d;
`ifdef MEM_PORT_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign o_cmd_ready = (state_q == ST_IDLE);
   assign o_rsp_valid = (state_q == ST_RESP);
   assign o_rsp_rdata = rdata_q;
   assign o_req_rd    = req_rd_q;
   assign o_req_wr    = req_wr_q;
   assign o_proc_addr = addr_q;
   assign o_proc_wr   = wdata_q;
   assign o_wr_size   = size_q;

`ifdef MEM_PORT_TIMEOUT_EN
   assign o_rsp_err = err_q;
`else
   assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Scoreboard bench for mem_port_ctrl: the driver pushes expected responses and request
// lengths, an independent negedge monitor pops and compares them.
module tb_mem_port_ctrl;
   localparam int BW = 128;
   localparam int AW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic          i_cmd_we = 1'b0;
   logic [AW-1:0] i_cmd_addr = '0;
   logic [BW-1:0] i_cmd_wdata = '0;
   logic [2:0]    i_cmd_size = '0;
   logic          o_rsp_valid;
   logic          i_rsp_ready = 1'b1;
   logic [BW-1:0] o_rsp_rdata;
   logic          o_rsp_err;
   logic          o_req_rd, o_req_wr;
   logic          i_grant_rd = 1'b0, i_grant_wr = 1'b0;
   logic [AW-1:0] o_proc_addr;
   logic [BW-1:0] o_proc_wr;
   logic [2:0]    o_wr_size;
   logic [BW-1:0] i_proc_rd = '0;

   mem_port_ctrl #(.BUS_SIZE(BW), .TIMEOUT(TO), .ADDR_SIZE(AW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
      .i_cmd_wdata(i_cmd_wdata), .i_cmd_size(i_cmd_size),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_req_rd(o_req_rd), .o_req_wr(o_req_wr),
      .i_grant_rd(i_grant_rd), .i_grant_wr(i_grant_wr),
      .o_proc_addr(o_proc_addr), .o_proc_wr(o_proc_wr),
      .o_wr_size(o_wr_size), .i_proc_rd(i_proc_rd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [BW-1:0] rdata;
      logic          err;
   } rsp_t;

   rsp_t exp_q[$];
   int   len_q[$];
   int   checks = 0;
   int   failures = 0;
   int   bp_hold = 0;
   bit   rnd_ready = 1'b0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Response acceptance: forced low for bp_hold valid cycles, otherwise random or always ready.
   always @(posedge clk) begin
      #1;
      if (bp_hold > 0) begin
         i_rsp_ready = 1'b0;
         if (o_rsp_valid) bp_hold--;
      end else if (rnd_ready) begin
         i_rsp_ready = ($urandom_range(0, 2) != 0);
      end else begin
         i_rsp_ready = 1'b1;
      end
   end

   int req_cnt = 0;
   bit prev_hs = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         req_cnt = 0;
         prev_hs = 1'b0;
      end else begin
         if (prev_hs) check("ready_after_hs", BW'(o_cmd_ready), BW'(1));
         prev_hs = 1'b0;
         if (o_req_rd || o_req_wr) begin
            check("req_onehot", BW'(o_req_rd & o_req_wr), BW'(0));
            req_cnt++;
         end else if (req_cnt > 0) begin
            if (len_q.size() == 0) check("req_len_unexpected", BW'(req_cnt), BW'(0));
            else check("req_len", BW'(req_cnt), BW'(len_q.pop_front()));
            req_cnt = 0;
         end
         if (o_rsp_valid) begin
            check("busy_not_ready", BW'(o_cmd_ready), BW'(0));
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", BW'(o_rsp_valid), BW'(0));
            end else begin
               check("rsp_rdata", o_rsp_rdata, exp_q[0].rdata);
               check("rsp_err", BW'(o_rsp_err), BW'(exp_q[0].err));
               if (i_rsp_ready) begin
                  void'(exp_q.pop_front());
                  prev_hs = 1'b1;
               end
            end
         end
      end
   end

   task automatic wait_ready();
      int w = 0;
      while (!o_cmd_ready && w < 200) begin
         i_grant_rd = 1'($urandom_range(0, 1));
         i_grant_wr = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         w++;
      end
      check("cmd_ready_wait", BW'(o_cmd_ready), BW'(1));
   endtask

   task automatic check_req(input logic we, input logic [AW-1:0] addr,
                            input logic [BW-1:0] wd, input logic [2:0] sz);
      check("req_dir", BW'({o_req_wr, o_req_rd}), BW'({we, !we}));
      check("proc_addr", BW'(o_proc_addr), BW'(addr));
      check("proc_wr", o_proc_wr, wd);
      check("wr_size", BW'(o_wr_size), BW'(sz));
   endtask

   // dly = REQ cycles before the grant cycle; no_grant runs dly cycles and expects a timeout.
   task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                         input logic [2:0] sz, input int dly, input logic [BW-1:0] rdv,
                         input bit no_grant);
      wait_ready();
      i_grant_rd  = 1'b0;
      i_grant_wr  = 1'b0;
      i_cmd_valid = 1'b1;
      i_cmd_we    = we;
      i_cmd_addr  = addr;
      i_cmd_wdata = wd;
      i_cmd_size  = sz;
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
      i_cmd_we    = 1'($urandom_range(0, 1));
      i_cmd_addr  = $urandom();
      i_cmd_wdata = rnd_data();
      i_cmd_size  = 3'($urandom_range(0, 7));
      if (no_grant) begin
         exp_q.push_back('{rdata: '0, err: 1'b1});
         len_q.push_back(dly);
      end
      for (int c = 0; c < dly; c++) begin
         check_req(we, addr, wd, sz);
         if (we) i_grant_rd = 1'($urandom_range(0, 1));
         else    i_grant_wr = 1'($urandom_range(0, 1));
         i_proc_rd = rnd_data();
         @(posedge clk); #1;
      end
      if (!no_grant) begin
         check_req(we, addr, wd, sz);
         if (we) begin
            i_grant_wr = 1'b1;
            i_grant_rd = 1'($urandom_range(0, 1));
         end else begin
            i_grant_rd = 1'b1;
            i_grant_wr = 1'($urandom_range(0, 1));
         end
         i_proc_rd = rdv;
         exp_q.push_back('{rdata: (we ? '0 : rdv), err: 1'b0});
         len_q.push_back(dly + 1);
         @(posedge clk); #1;
      end
      i_grant_rd = 1'b0;
      i_grant_wr = 1'b0;
      i_proc_rd  = rnd_data();
      check("req_drop", BW'({o_req_wr, o_req_rd}), BW'(0));
   endtask

   initial begin
      #2;
      check("rst_req", BW'({o_req_wr, o_req_rd}), BW'(0));
      check("rst_rsp_valid", BW'(o_rsp_valid), BW'(0));
      check("rst_rsp_err", BW'(o_rsp_err), BW'(0));
      check("rst_rdata", o_rsp_rdata, BW'(0));
      check("rst_proc_addr", BW'(o_proc_addr), BW'(0));
      check("rst_proc_wr", o_proc_wr, BW'(0));
      check("rst_wr_size", BW'(o_wr_size), BW'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("ready_after_rst", BW'(o_cmd_ready), BW'(1));

      // Write with immediate grant, then read with a 5-cycle grant delay.
      do_cmd(1'b1, 32'h10, {16{8'hA5}}, 3'd3, 0, rnd_data(), 1'b0);
      do_cmd(1'b0, 32'h20, rnd_data(), 3'd0, 5, BW'(32'h1234), 1'b0);

      // Backpressure: response held for 4 cycles.
      wait_ready();
      bp_hold = 4;
      do_cmd(1'b0, 32'h30, rnd_data(), 3'd1, 1, rnd_data(), 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("bp_valid_held", BW'(o_rsp_valid), BW'(1));
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("bp_ready_after", BW'(o_cmd_ready), BW'(1));

      // Grants while idle change nothing.
      i_grant_rd = 1'b1;
      i_grant_wr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("idle_grant_ready", BW'(o_cmd_ready), BW'(1));
         check("idle_grant_valid", BW'(o_rsp_valid), BW'(0));
      end
      do_cmd(1'b0, 32'h44, rnd_data(), 3'd2, 4, rnd_data(), 1'b0);

      rnd_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         do_cmd(1'($urandom_range(0, 1)), $urandom(), rnd_data(), 3'($urandom_range(0, 7)),
                $urandom_range(0, 6), rnd_data(), 1'b0);
      end
      rnd_ready = 1'b0;

`ifdef MEM_PORT_TIMEOUT_EN
      do_cmd(1'b0, 32'h50, rnd_data(), 3'd0, TO, rnd_data(), 1'b1);
      do_cmd(1'b1, 32'h54, rnd_data(), 3'd5, TO, rnd_data(), 1'b1);
      do_cmd(1'b0, 32'h58, rnd_data(), 3'd0, TO - 1, rnd_data(), 1'b0);
`else
      do_cmd(1'b0, 32'h50, rnd_data(), 3'd0, 20, rnd_data(), 1'b0);
`endif

      // Reset while a read is waiting for its grant.
      wait_ready();
      i_grant_rd  = 1'b0;
      i_grant_wr  = 1'b0;
      i_cmd_valid = 1'b1;
      i_cmd_we    = 1'b0;
      i_cmd_addr  = 32'h60;
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_req_rd", BW'(o_req_rd), BW'(1));
      rst = 1'b1;
      #1;
      check("rst_async_req", BW'(o_req_rd), BW'(0));
      check("rst_async_valid", BW'(o_rsp_valid), BW'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("post_rst_valid", BW'(o_rsp_valid), BW'(0));
         check("post_rst_ready", BW'(o_cmd_ready), BW'(1));
         @(posedge clk); #1;
      end

      check("exp_q_empty", BW'(exp_q.size()), BW'(0));
      check("len_q_empty", BW'(len_q.size()), BW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter BUS_SIZE, default 128, data bus width in bits; must match shared_mem BUS_SIZE.
REQ-002 Parameter TIMEOUT, default 255, grant-wait limit in cycles; used only with MEM_PORT_TIMEOUT_EN.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 i_clk  in  1  clock; all state changes on rising edge.
REQ-005 i_rst  in  1  asynchronous active-high reset.
REQ-006 i_cmd_valid  in  1  core command present.
REQ-007 o_cmd_ready  out  1  block can accept a command.
REQ-008 i_cmd_we  in  1  1 = write, 0 = read.
REQ-009 i_cmd_addr  in  addr_t  command address.
REQ-010 i_cmd_wdata  in  BUS_SIZE  write data.
REQ-011 i_cmd_size  in  3  write size code, passed through unchanged.
REQ-012 o_rsp_valid  out  1  response present.
REQ-013 i_rsp_ready  in  1  core accepts response.
REQ-014 o_rsp_rdata  out  BUS_SIZE  read data; 0 for writes and errors.
REQ-015 o_rsp_err  out  1  request aborted.
REQ-016 o_req_rd / o_req_wr  out  1 each  arbiter request lines.
REQ-017 i_grant_rd / i_grant_wr  in  1 each  this port's arbiter grant bits.
REQ-018 o_proc_addr  out  addr_t; o_proc_wr  out  BUS_SIZE; o_wr_size  out  3: shared-memory port signals.
REQ-019 i_proc_rd  in  BUS_SIZE  shared-memory read data for this port.

Function
REQ-020 FSM states: IDLE, REQ, RESP.
REQ-021 o_cmd_ready = 1 only in IDLE; a command is accepted when i_cmd_valid && o_cmd_ready on a clock edge.
REQ-022 On accept: register we, addr, wdata and size; go to REQ. o_proc_addr, o_proc_wr and o_wr_size drive the registered values and stay stable until the next accept.
REQ-023 REQ state: o_req_wr = we and o_req_rd = !we, both registered. The other request line stays 0.
REQ-024 Write completes on the edge where i_grant_wr = 1 in REQ. Shared memory commits the write that same edge. Response: rdata = 0, err = 0.
REQ-025 Read completes on the edge where i_grant_rd = 1 in REQ. i_proc_rd is captured into o_rsp_rdata on that edge, with err = 0.
REQ-026 On completion, deassert the request the next cycle. The arbiter sees exactly one granted cycle per command.
REQ-027 Grants are ignored outside REQ, and a grant for the non-requested direction is ignored.
REQ-028 If both grants are high in REQ, only the grant matching we counts.
REQ-029 After completion the FSM is in RESP. o_rsp_valid = 1 until the edge where i_rsp_ready = 1, then the FSM returns to IDLE. o_rsp_rdata and o_rsp_err hold stable while valid.
REQ-030 Minimum command-to-response latency is 2 cycles: accept edge, then grant in the first REQ cycle.
REQ-031 No new command is accepted in the same cycle as a response handshake; o_cmd_ready rises the following cycle.

Reset
REQ-032 While i_rst = 1, asynchronously: state = IDLE; o_req_rd, o_req_wr, o_rsp_valid and o_rsp_err = 0; o_rsp_rdata, o_proc_addr, o_proc_wr and o_wr_size = 0.
REQ-033 o_cmd_ready = 1 in the first cycle after reset deasserts.
REQ-034 Reset during REQ or RESP discards the in-flight command. No response is produced and the request line drops immediately.

Configuration
REQ-035 Macro MEM_PORT_TIMEOUT_EN, when defined, adds a wait counter:
- counter is cleared on entry to REQ and increments each REQ cycle without a matching grant;
- when it reaches TIMEOUT, the request is dropped and the FSM goes to RESP with o_rsp_err = 1, o_rsp_rdata = 0;
- a grant on the same edge the counter reaches TIMEOUT wins, and the command completes normally.
REQ-036 Without MEM_PORT_TIMEOUT_EN: REQ waits for a grant indefinitely, no counter logic exists, and o_rsp_err is constant 0.

Verification
REQ-037 Write: cmd we = 1, addr 0x10, wdata 0xA5..A5, size 3; grant_wr in the first REQ cycle -> req_wr high exactly 1 cycle, addr/wdata/size stable, rsp_valid the next cycle with err = 0, rdata = 0.
REQ-038 Read with delayed grant: cmd we = 0, addr 0x20; grant_rd after 5 cycles with i_proc_rd = 0x1234 -> req_rd high 6 cycles, rsp_rdata = 0x1234, err = 0.
REQ-039 Backpressure: i_rsp_ready low 4 cycles -> rsp_valid and rdata held, cmd_ready = 0 throughout; cmd_ready = 1 the cycle after the handshake.
REQ-040 Spurious grants: grant_wr during a read REQ, and grants while IDLE -> no completion, no state change; a later grant_rd completes normally.
REQ-041 Reset mid-REQ: assert i_rst while req_rd = 1 -> req_rd = 0 asynchronously, no rsp_valid after release, cmd_ready = 1.
REQ-042 With MEM_PORT_TIMEOUT_EN and TIMEOUT = 8: no grant -> request drops after 8 REQ cycles, rsp_err = 1, rdata = 0; a grant on the 8th cycle completes normally with err = 0.
